// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: shared types and constants for the nibble-serial comparator
package cmp_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic sm;
    } res_t;

    localparam res_t RES_NONE = '{eq: 1'b0, gt: 1'b0, sm: 1'b0};
    localparam res_t RES_EQ   = '{eq: 1'b1, gt: 1'b0, sm: 1'b0};
    localparam res_t RES_GT   = '{eq: 1'b0, gt: 1'b1, sm: 1'b0};
    localparam res_t RES_SM   = '{eq: 1'b0, gt: 1'b0, sm: 1'b1};

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// cmp_seq_ctrl_if: command and result handshake bundle of cmp_seq_ctrl
interface cmp_seq_ctrl_if #(parameter int NIBBLES = 4);

    localparam int W  = cmp_seq_pkg::NIB_W * NIBBLES;
    localparam int SW = $clog2(NIBBLES + 1);

    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          res_valid;
    logic          res_ready;
    logic          eq;
    logic          gt;
    logic          sm;
    logic [SW-1:0] steps;

    modport master (
        output start_valid, a, b, res_ready,
        input  start_ready, res_valid, eq, gt, sm, steps
    );

    modport slave (
        input  start_valid, a, b, res_ready,
        output start_ready, res_valid, eq, gt, sm, steps
    );

endinterface

// File: rtl/cmp_nibble.sv
// cmp_nibble: combinational 4-bit unsigned magnitude comparator
module cmp_nibble
    import cmp_seq_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic             eq,
    output logic             gt,
    output logic             sm
);

    assign eq = x == y;
    assign gt = x > y;
    assign sm = x < y;

endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: compares two multi-nibble operands one nibble per clock, MSB first,
// stopping at the first unequal nibble
module cmp_seq_ctrl
    import cmp_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_seq_ctrl_if.slave    bus
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int SW = $clog2(NIBBLES + 1);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] steps_q, steps_d;
    res_t          res_q, res_d;

    logic             accept;
    logic             last;
    logic [NIB_W-1:0] a_nib, b_nib;
    logic             nib_eq, nib_gt, nib_sm;

    assign accept = bus.start_valid && state_q == IDLE;
    assign last   = idx_q == '0;
    assign a_nib  = a_q[int'(idx_q) * NIB_W +: NIB_W];
    assign b_nib  = b_q[int'(idx_q) * NIB_W +: NIB_W];

    cmp_nibble u_nib (
        .x  (a_nib),
        .y  (b_nib),
        .eq (nib_eq),
        .gt (nib_gt),
        .sm (nib_sm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = (!nib_eq || last) ? DONE : RUN;
            DONE:    state_d = bus.res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers only move on a decision, so they hold after DONE
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        res_d   = res_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            idx_d   = IW'(NIBBLES - 1);
            steps_d = '0;
        end else if (state_q == RUN) begin
            steps_d = steps_q + SW'(1);
            if (!nib_eq || last)
                res_d = '{eq: nib_eq, gt: nib_gt, sm: nib_sm};
            else
                idx_d = idx_q - IW'(1);
        end
    end

    always_comb begin
        bus.start_ready = state_q == IDLE;
        bus.res_valid   = state_q == DONE;
        bus.eq          = res_q.eq;
        bus.gt          = res_q.gt;
        bus.sm          = res_q.sm;
        bus.steps       = steps_q;
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: scoreboard bench for cmp_seq_ctrl with directed and random commands
module tb_cmp_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic eq;
        logic gt;
        logic sm;
        int   steps;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rr_rand;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    cmp_seq_ctrl_if #(.NIBBLES(N)) bus ();

    cmp_seq_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Decision point is the first nibble (from the MSB) where the operands differ
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, int acc);
        exp_t e;
        logic found = 1'b0;
        e.steps = N;
        for (int j = 1; j <= N; j++)
            if (!found && (x >> (4 * (N - j))) != (y >> (4 * (N - j)))) begin
                e.steps = j;
                found = 1'b1;
            end
        e.eq  = x == y;
        e.gt  = x > y;
        e.sm  = x < y;
        e.acc = acc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_rand) bus.res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(logic [W-1:0] x, logic [W-1:0] y);
        logic done = 1'b0;
        bus.start_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.start_ready) begin
                q.push_back(model(x, y, cyc + 1));
                done = 1'b1;
            end
            tick();
        end
        bus.start_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: start_ready never seen for a=%h b=%h", x, y);
        end
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (q.size() == 0 && bus.start_ready) done = 1'b1;
            tick();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding", q.size());
        end
    endtask

    logic vprev;
    int   rise;

    always @(negedge clk) begin
        if (!rst_n) begin
            vprev = 1'b0;
        end else begin
            if (bus.res_valid) begin
                if (!vprev) rise = cyc;
                chk("ready_in_done", int'(bus.start_ready), 0);
                chk("one_hot", int'(bus.eq) + int'(bus.gt) + int'(bus.sm), 1);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: res_valid with nothing outstanding");
                end else begin
                    chk("eq", int'(bus.eq), int'(q[0].eq));
                    chk("gt", int'(bus.gt), int'(q[0].gt));
                    chk("sm", int'(bus.sm), int'(q[0].sm));
                    chk("steps", int'(bus.steps), q[0].steps);
                    if (!vprev) chk("latency", rise - q[0].acc, q[0].steps);
                    if (bus.res_ready) void'(q.pop_front());
                end
            end
            vprev = bus.res_valid;
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_start_ready"}, int'(bus.start_ready), 1);
        chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
        chk({tag, "_eq"}, int'(bus.eq), 0);
        chk({tag, "_gt"}, int'(bus.gt), 0);
        chk({tag, "_sm"}, int'(bus.sm), 0);
        chk({tag, "_steps"}, int'(bus.steps), 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int pos;
        rst_n = 1'b0;
        rr_rand = 1'b0;
        bus.start_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_rst");

        bus.res_ready = 1'b1;
        send(16'h1234, 16'h1234);
        drain();
        send(16'h8000, 16'h7FFF);
        drain();
        send(16'h12A5, 16'h12A6);
        send(16'h0F00, 16'h0E00);
        drain();

        // Consumer stalls while requester already holds the next command
        bus.res_ready = 1'b0;
        send(16'h3000, 16'h4000);
        bus.start_valid = 1'b1;
        bus.a = 16'h5555;
        bus.b = 16'h5554;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stall_start_ready", int'(bus.start_ready), 0);
        end
        bus.res_ready = 1'b1;
        send(16'h5555, 16'h5554);
        drain();

        send(16'h1111, 16'h1112);
        bus.a = 16'hFFFF;
        drain();

        send(16'h1111, 16'h1112);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_run_rst");
        q.delete();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("no_result_after_rst", int'(bus.res_valid), 0);

        rr_rand = 1'b1;
        for (int t = 0; t < 60; t++) begin
            ra = W'($urandom);
            rb = ra;
            pos = $urandom_range(0, N);
            if (pos < N) begin
                rb[pos * 4 +: 4] = ra[pos * 4 +: 4] ^ 4'($urandom_range(1, 15));
                for (int i = 0; i < pos; i++) rb[i * 4 +: 4] = 4'($urandom);
            end
            send(ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
